// File: rtl/vin_clip_decim.sv
// Video input front end: frame-start detect, crop window, integer decimation,
// and an output FIFO with a first-word fall-through valid/ready register.
module vin_clip_decim #(
  parameter int DATA_WIDTH     = 16,
  parameter int COORD_BITS     = 12,
  parameter int FIFO_ADDR_BITS = 9
) (
  input  logic                  pixel_clk,
  input  logic                  rst_n,
  input  logic                  vs,
  input  logic                  pixel_de,
  input  logic [DATA_WIDTH-1:0] pixel_data,
  input  logic [COORD_BITS-1:0] s_width,
  input  logic [COORD_BITS-1:0] s_height,
  input  logic [COORD_BITS-1:0] clipper_left,
  input  logic [COORD_BITS-1:0] clipper_top,
  input  logic [COORD_BITS-1:0] clipper_width,
  input  logic [COORD_BITS-1:0] clipper_height,
  input  logic [2:0]            h_decim,
  input  logic [2:0]            v_decim,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_sof,
  output logic                  out_eol,
  output logic                  frame_start,
  output logic                  overflow
);

  // Output handshake: a pixel transfers on a rising edge where out_valid && out_ready;
  // while out_valid && !out_ready the payload (out_data/out_sof/out_eol) holds steady.

  localparam int CW1   = COORD_BITS + 1;
  localparam int CW4   = COORD_BITS + 4;
  localparam int EW    = DATA_WIDTH + 2;
  localparam int DEPTH = 1 << FIFO_ADDR_BITS;

  localparam logic [COORD_BITS-1:0]   C_ONE  = 1;
  localparam logic [CW1-1:0]          C1_ONE = 1;
  localparam logic [FIFO_ADDR_BITS-1:0] P_ONE = 1;
  localparam logic [FIFO_ADDR_BITS:0]   N_ONE = 1;

  logic                  vs_d0, vs_d1;
  logic                  de_r;
  logic [DATA_WIDTH-1:0] data_r;
  logic                  start, armed;
  logic [COORD_BITS-1:0] x, y;
  logic [2:0]            hphase, vphase;
  logic                  sof_pending;

  logic [COORD_BITS-1:0] sh_swidth, sh_sheight, sh_left, sh_top, sh_cwidth, sh_cheight;
  logic [2:0]            sh_hd, sh_vd;

  logic [CW1-1:0]        right, bottom, x_w, y_w;
  logic                  in_win, first_px, px, keep, eol_c, line_end;
  logic [2:0]            hph_cur, hph_next, vph_next;

  logic                  s1_valid, s1_sof, s1_eol;
  logic [DATA_WIDTH-1:0] s1_data;

  logic [EW-1:0]             mem [DEPTH];
  logic [EW-1:0]             head;
  logic [FIFO_ADDR_BITS-1:0] wr_ptr, rd_ptr;
  logic [FIFO_ADDR_BITS:0]   count;
  logic                      full, push, pop;

  always_comb begin
    start       = vs_d0 && !vs_d1;
    frame_start = start;
    x_w         = {1'b0, x};
    y_w         = {1'b0, y};
    right       = {1'b0, sh_left} + {1'b0, sh_cwidth};
    bottom      = {1'b0, sh_top} + {1'b0, sh_cheight};
    in_win      = (x_w > {1'b0, sh_left}) && (x_w <= right) &&
                  (y_w > {1'b0, sh_top}) && (y_w <= bottom);
    // The horizontal phase restarts on the first in-window column of every line.
    first_px    = (x_w == ({1'b0, sh_left} + C1_ONE));
    hph_cur     = first_px ? 3'd0 : hphase;
    hph_next    = ((hph_cur + 3'd1) == sh_hd) ? 3'd0 : (hph_cur + 3'd1);
    vph_next    = ((vphase + 3'd1) == sh_vd) ? 3'd0 : (vphase + 3'd1);
    px          = de_r && armed && !start;
    keep        = px && in_win && (hph_cur == 3'd0) && (vphase == 3'd0);
    eol_c       = ({4'b0000, x} + {{(CW4-3){1'b0}}, sh_hd}) > {3'b000, right};
    line_end    = in_win && ((x == sh_swidth) || (x_w == right));
    full        = count[FIFO_ADDR_BITS];
    push        = s1_valid && !full;
    pop         = (count != '0) && (!out_valid || out_ready);
    head        = mem[rd_ptr];
  end

  always_ff @(posedge pixel_clk) begin
    if (!rst_n) begin
      vs_d0  <= 1'b0;
      vs_d1  <= 1'b0;
      de_r   <= 1'b0;
      data_r <= '0;
    end else begin
      vs_d0  <= vs;
      vs_d1  <= vs_d0;
      de_r   <= pixel_de;
      data_r <= pixel_data;
    end
  end

  always_ff @(posedge pixel_clk) begin
    if (!rst_n) begin
      armed       <= 1'b0;
      x           <= C_ONE;
      y           <= C_ONE;
      hphase      <= 3'd0;
      vphase      <= 3'd0;
      sof_pending <= 1'b0;
      sh_swidth   <= '0;
      sh_sheight  <= '0;
      sh_left     <= '0;
      sh_top      <= '0;
      sh_cwidth   <= '0;
      sh_cheight  <= '0;
      sh_hd       <= 3'd1;
      sh_vd       <= 3'd1;
      s1_valid    <= 1'b0;
      s1_sof      <= 1'b0;
      s1_eol      <= 1'b0;
      s1_data     <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      overflow    <= 1'b0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_sof     <= 1'b0;
      out_eol     <= 1'b0;
    end else if (start) begin
      // Frame start flushes everything queued from the previous frame.
      armed       <= 1'b1;
      x           <= C_ONE;
      y           <= C_ONE;
      hphase      <= 3'd0;
      vphase      <= 3'd0;
      sof_pending <= 1'b1;
      sh_swidth   <= s_width;
      sh_sheight  <= s_height;
      sh_left     <= clipper_left;
      sh_top      <= clipper_top;
      sh_cwidth   <= clipper_width;
      sh_cheight  <= clipper_height;
      sh_hd       <= (h_decim == 3'd0) ? 3'd1 : h_decim;
      sh_vd       <= (v_decim == 3'd0) ? 3'd1 : v_decim;
      s1_valid    <= 1'b0;
      s1_sof      <= 1'b0;
      s1_eol      <= 1'b0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      overflow    <= 1'b0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_sof     <= 1'b0;
      out_eol     <= 1'b0;
    end else begin
      if (px) begin
        if (x == sh_swidth) begin
          x <= C_ONE;
          y <= (y == sh_sheight) ? C_ONE : (y + C_ONE);
        end else begin
          x <= x + C_ONE;
        end
        if (in_win)   hphase <= hph_next;
        if (line_end) vphase <= vph_next;
        if (keep)     sof_pending <= 1'b0;
      end
      s1_valid <= keep;
      s1_sof   <= keep && sof_pending;
      s1_eol   <= keep && eol_c;
      s1_data  <= data_r;
      if (s1_valid && full) overflow <= 1'b1;
      if (push) wr_ptr <= wr_ptr + P_ONE;
      if (pop) begin
        rd_ptr    <= rd_ptr + P_ONE;
        out_valid <= 1'b1;
        out_data  <= head[DATA_WIDTH-1:0];
        out_eol   <= head[DATA_WIDTH];
        out_sof   <= head[DATA_WIDTH+1];
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (push && !pop)      count <= count + N_ONE;
      else if (!push && pop) count <= count - N_ONE;
    end
  end

  always_ff @(posedge pixel_clk) begin
    if (rst_n && !start && push) mem[wr_ptr] <= {s1_sof, s1_eol, s1_data};
  end

endmodule

// File: tb/tb_vin_clip_decim.sv
// Bench for vin_clip_decim: directed 8x4 frames, a frame-level reference model
// filling an expected queue, and one output monitor comparing every transfer.
module tb_vin_clip_decim;

  logic        pixel_clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        vs = 1'b0;
  logic        pixel_de = 1'b0;
  logic [15:0] pixel_data = '0;
  logic [11:0] s_width = 12'd8, s_height = 12'd4;
  logic [11:0] clipper_left = '0, clipper_top = '0;
  logic [11:0] clipper_width = 12'd8, clipper_height = 12'd4;
  logic [2:0]  h_decim = 3'd1, v_decim = 3'd1;
  logic        out_valid, out_ready = 1'b1;
  logic [15:0] out_data;
  logic        out_sof, out_eol, frame_start, overflow;

  vin_clip_decim #(.DATA_WIDTH(16), .COORD_BITS(12), .FIFO_ADDR_BITS(4)) dut (
    .pixel_clk(pixel_clk), .rst_n(rst_n), .vs(vs), .pixel_de(pixel_de),
    .pixel_data(pixel_data), .s_width(s_width), .s_height(s_height),
    .clipper_left(clipper_left), .clipper_top(clipper_top),
    .clipper_width(clipper_width), .clipper_height(clipper_height),
    .h_decim(h_decim), .v_decim(v_decim), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_sof(out_sof),
    .out_eol(out_eol), .frame_start(frame_start), .overflow(overflow)
  );

  // clock / reset bookkeeping
  always #5 pixel_clk = ~pixel_clk;
  int cyc = 0;
  always @(posedge pixel_clk) cyc <= cyc + 1;
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  int checks = 0;
  int errors = 0;
  logic [17:0] exp_q[$];
  int n_out = 0;
  bit lat_en = 0;
  int first_px_cyc = 0;
  int first_valid_cyc = 0;
  bit stab_en = 0;
  bit hold_pend = 0;
  logic [17:0] held;
  bit rdy_mode = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // scoreboard monitor: one comparison per output transfer
  always @(negedge pixel_clk) begin
    if (lat_en && out_valid) begin
      first_valid_cyc = cyc;
      lat_en = 0;
    end
    if (out_valid && out_ready) begin
      n_out++;
      if (exp_q.size() == 0) begin
        chk("unexpected_output", {14'd0, out_sof, out_eol, out_data}, 32'hFFFF_FFFF);
      end else begin
        chk("out_pixel", {14'd0, out_sof, out_eol, out_data}, {14'd0, exp_q.pop_front()});
      end
    end
    if (stab_en) begin
      if (hold_pend) chk("hold_stable", {13'd0, out_valid, out_sof, out_eol, out_data}, {13'd0, 1'b1, held});
      hold_pend = out_valid && !out_ready;
      held = {out_sof, out_eol, out_data};
    end else begin
      hold_pend = 0;
    end
  end

  initial begin
    forever begin
      @(posedge pixel_clk);
      #1;
      if (rdy_mode) out_ready = ((cyc % 3) != 0);
    end
  end

  // reference model: kept pixels of one frame from the window/decimation rules
  task automatic model_frame(input int w, input int h, input int l, input int t,
                             input int cw, input int ch, input int hdr, input int vdr,
                             input int cap);
    int hd = (hdr == 0) ? 1 : hdr;
    int vd = (vdr == 0) ? 1 : vdr;
    int n = 0;
    logic first = 1'b1;
    logic eolb;
    logic [15:0] dv;
    for (int yy = 1; yy <= h; yy++) begin
      for (int xx = 1; xx <= w; xx++) begin
        if (xx > l && xx <= l + cw && yy > t && yy <= t + ch &&
            ((xx - l - 1) % hd) == 0 && ((yy - t - 1) % vd) == 0) begin
          eolb = (xx + hd > l + cw);
          dv = 16'(yy * 16 + xx);
          if (n < cap) exp_q.push_back({first, eolb, dv});
          first = 1'b0;
          n++;
        end
      end
    end
  endtask

  // driver tasks
  task automatic set_cfg(input int l, input int t, input int cw, input int ch,
                         input int hd, input int vd);
    s_width = 12'd8;
    s_height = 12'd4;
    clipper_left = 12'(l);
    clipper_top = 12'(t);
    clipper_width = 12'(cw);
    clipper_height = 12'(ch);
    h_decim = 3'(hd);
    v_decim = 3'(vd);
  endtask

  task automatic vs_pulse();
    @(posedge pixel_clk);
    #1 vs = 1'b1;
    @(negedge pixel_clk);
    chk("frame_start_before", {31'd0, frame_start}, 32'd0);
    @(negedge pixel_clk);
    chk("frame_start_pulse", {31'd0, frame_start}, 32'd1);
    @(negedge pixel_clk);
    chk("frame_start_after", {31'd0, frame_start}, 32'd0);
    @(posedge pixel_clk);
    #1 vs = 1'b0;
  endtask

  task automatic drive_line(input int yy, input int x0, input int x1, input int gap);
    for (int xx = x0; xx <= x1; xx++) begin
      @(posedge pixel_clk);
      #1;
      if (xx == 1 && yy == 1) first_px_cyc = cyc;
      pixel_de = 1'b1;
      pixel_data = 16'(yy * 16 + xx);
    end
    for (int g = 0; g < gap; g++) begin
      @(posedge pixel_clk);
      #1 pixel_de = 1'b0;
    end
  endtask

  task automatic drive_frame(input int w, input int h, input int gap,
                             input int chg_row, input int new_left);
    for (int yy = 1; yy <= h; yy++) begin
      if (yy == chg_row) clipper_left = 12'(new_left);
      drive_line(yy, 1, w, gap);
    end
    @(posedge pixel_clk);
    #1 pixel_de = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int t = 0;
    while (exp_q.size() != 0 && t < 400) begin
      @(posedge pixel_clk);
      t++;
    end
    chk(name, exp_q.size(), 0);
    exp_q.delete();
    repeat (6) @(posedge pixel_clk);
  endtask

  task automatic chk_reset_values(input string tag);
    @(negedge pixel_clk);
    chk({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_out_data"}, {16'd0, out_data}, 32'd0);
    chk({tag, "_out_sof"}, {31'd0, out_sof}, 32'd0);
    chk({tag, "_out_eol"}, {31'd0, out_eol}, 32'd0);
    chk({tag, "_frame_start"}, {31'd0, frame_start}, 32'd0);
    chk({tag, "_overflow"}, {31'd0, overflow}, 32'd0);
  endtask

  initial begin
    repeat (3) @(posedge pixel_clk);
    #1 rst_n = 1'b1;
    chk_reset_values("reset");

    // disarmed until the first frame start
    n_out = 0;
    drive_frame(8, 4, 0, 0, 0);
    repeat (8) @(posedge pixel_clk);
    chk("disarmed_outputs", n_out, 0);

    // pass-through with first-output latency
    set_cfg(0, 0, 8, 4, 1, 1);
    vs_pulse();
    model_frame(8, 4, 0, 0, 8, 4, 1, 1, 1000);
    chk("pt_model_size", exp_q.size(), 32);
    chk("pt_model_first", {14'd0, exp_q[0]}, {14'd0, 2'b10, 16'h0011});
    chk("pt_model_last", {14'd0, exp_q[31]}, {14'd0, 2'b01, 16'h0048});
    n_out = 0;
    lat_en = 1;
    drive_frame(8, 4, 0, 0, 0);
    wait_drain("pt_drain");
    chk("pt_count", n_out, 32);
    chk("pt_latency", first_valid_cyc - (first_px_cyc + 1), 3);
    chk("pt_overflow", {31'd0, overflow}, 32'd0);

    // crop
    set_cfg(2, 1, 3, 2, 1, 1);
    vs_pulse();
    model_frame(8, 4, 2, 1, 3, 2, 1, 1, 1000);
    chk("crop_model_size", exp_q.size(), 6);
    chk("crop_model_eol", {14'd0, exp_q[2]}, {14'd0, 2'b01, 16'h0025});
    n_out = 0;
    drive_frame(8, 4, 0, 0, 0);
    wait_drain("crop_drain");
    chk("crop_count", n_out, 6);

    // decimate by 2 both ways
    set_cfg(0, 0, 8, 4, 2, 2);
    vs_pulse();
    model_frame(8, 4, 0, 0, 8, 4, 2, 2, 1000);
    chk("dec_model_size", exp_q.size(), 8);
    chk("dec_model_eol", {14'd0, exp_q[3]}, {14'd0, 2'b01, 16'h0017});
    chk("dec_model_row3", {14'd0, exp_q[4]}, {14'd0, 2'b00, 16'h0031});
    n_out = 0;
    drive_frame(8, 4, 0, 0, 0);
    wait_drain("dec_drain");
    chk("dec_count", n_out, 8);

    // h_decim 0 acts as 1, v_decim 3
    set_cfg(0, 0, 8, 4, 0, 3);
    vs_pulse();
    model_frame(8, 4, 0, 0, 8, 4, 0, 3, 1000);
    chk("h0_model_size", exp_q.size(), 16);
    chk("h0_model_eol", {14'd0, exp_q[7]}, {14'd0, 2'b01, 16'h0018});
    chk("h0_model_row4", {14'd0, exp_q[8]}, {14'd0, 2'b00, 16'h0041});
    n_out = 0;
    drive_frame(8, 4, 0, 0, 0);
    wait_drain("h0_drain");
    chk("h0_count", n_out, 16);

    // backpressure with line gaps
    set_cfg(0, 0, 8, 4, 1, 1);
    vs_pulse();
    model_frame(8, 4, 0, 0, 8, 4, 1, 1, 1000);
    n_out = 0;
    rdy_mode = 1;
    stab_en = 1;
    drive_frame(8, 4, 4, 0, 0);
    wait_drain("bp_drain");
    rdy_mode = 0;
    stab_en = 0;
    @(negedge pixel_clk);
    out_ready = 1'b1;
    chk("bp_count", n_out, 32);
    chk("bp_overflow", {31'd0, overflow}, 32'd0);

    // overflow: 17 survive, sticky flag, flush on next start
    set_cfg(0, 0, 8, 4, 1, 1);
    out_ready = 1'b0;
    vs_pulse();
    model_frame(8, 4, 0, 0, 8, 4, 1, 1, 17);
    chk("ovf_model_size", exp_q.size(), 17);
    chk("ovf_model_last", {14'd0, exp_q[16]}, {14'd0, 2'b00, 16'h0031});
    n_out = 0;
    drive_frame(8, 4, 0, 0, 0);
    repeat (6) @(posedge pixel_clk);
    @(negedge pixel_clk);
    chk("ovf_set", {31'd0, overflow}, 32'd1);
    chk("ovf_valid_held", {31'd0, out_valid}, 32'd1);
    @(posedge pixel_clk);
    #1 out_ready = 1'b1;
    wait_drain("ovf_drain");
    chk("ovf_count", n_out, 17);
    chk("ovf_sticky", {31'd0, overflow}, 32'd1);
    out_ready = 1'b0;
    drive_frame(3, 1, 0, 0, 0);
    repeat (5) @(posedge pixel_clk);
    @(negedge pixel_clk);
    chk("flush_pre_valid", {31'd0, out_valid}, 32'd1);
    vs_pulse();
    @(negedge pixel_clk);
    chk("flush_overflow", {31'd0, overflow}, 32'd0);
    chk("flush_valid", {31'd0, out_valid}, 32'd0);
    out_ready = 1'b1;
    n_out = 0;
    repeat (10) @(posedge pixel_clk);
    chk("flush_discarded", n_out, 0);

    // config change mid-frame takes effect at the next start
    set_cfg(2, 1, 3, 2, 1, 1);
    vs_pulse();
    model_frame(8, 4, 2, 1, 3, 2, 1, 1, 1000);
    n_out = 0;
    drive_frame(8, 4, 0, 2, 0);
    wait_drain("cfg_old_drain");
    chk("cfg_old_count", n_out, 6);
    vs_pulse();
    model_frame(8, 4, 0, 1, 3, 2, 1, 1, 1000);
    chk("cfg_new_model_first", {14'd0, exp_q[0]}, {14'd0, 2'b10, 16'h0021});
    n_out = 0;
    drive_frame(8, 4, 0, 0, 0);
    wait_drain("cfg_new_drain");
    chk("cfg_new_count", n_out, 6);

    // reset in the middle of a frame
    set_cfg(0, 0, 8, 4, 1, 1);
    out_ready = 1'b0;
    vs_pulse();
    drive_line(1, 1, 8, 0);
    drive_line(2, 1, 2, 0);
    @(posedge pixel_clk);
    #1 pixel_de = 1'b0;
    repeat (4) @(posedge pixel_clk);
    @(negedge pixel_clk);
    chk("rst_pre_valid", {31'd0, out_valid}, 32'd1);
    chk("rst_pre_data", {16'd0, out_data}, 32'h0011);
    chk("rst_pre_sof", {31'd0, out_sof}, 32'd1);
    @(posedge pixel_clk);
    #1 rst_n = 1'b0;
    @(posedge pixel_clk);
    #1 rst_n = 1'b1;
    chk_reset_values("midrst");
    out_ready = 1'b1;
    n_out = 0;
    drive_line(2, 3, 8, 0);
    drive_line(3, 1, 8, 0);
    drive_line(4, 1, 8, 0);
    @(posedge pixel_clk);
    #1 pixel_de = 1'b0;
    repeat (8) @(posedge pixel_clk);
    chk("midrst_no_output", n_out, 0);
    vs_pulse();
    model_frame(8, 4, 0, 0, 8, 4, 1, 1, 1000);
    n_out = 0;
    drive_frame(8, 4, 0, 0, 0);
    wait_drain("midrst_next_drain");
    chk("midrst_next_count", n_out, 32);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vin_clip_decim.md
# vin_clip_decim

Parametrised pixel-domain front end for the video input path: detects frame start, crops the incoming stream to a clipper window, optionally decimates horizontally and vertically by integer factors, and buffers the surviving pixels in an internal FIFO with a valid/ready output carrying start-of-frame and end-of-line tags. It sits between the video decoder interface and the frame-buffer write controller. It generalises the fixed 16-bit crop-only path with configurable data width, FIFO depth, decimation, backpressure, and overflow reporting.

## Interface
- DATA_WIDTH, 16, pixel data width
- COORD_BITS, 12, width of coordinate/size inputs
- FIFO_ADDR_BITS, 9, FIFO memory depth = 2^FIFO_ADDR_BITS entries, plus one output register
- pixel_clk  in  1  sole clock; all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- vs  in  1  vertical sync; rising edge marks frame start
- pixel_de  in  1  input pixel valid
- pixel_data  in  DATA_WIDTH  input pixel
- s_width, s_height  in  COORD_BITS each  source frame size
- clipper_left, clipper_top, clipper_width, clipper_height  in  COORD_BITS each  crop window
- h_decim, v_decim  in  3 each  keep 1 of N pixels / lines; 0 is treated as 1
- out_valid  out  1  output pixel available
- out_ready  in  1  sink accepts when out_valid && out_ready
- out_data  out  DATA_WIDTH  output pixel
- out_sof  out  1  out_data is first kept pixel of frame
- out_eol  out  1  out_data is last kept pixel of a kept line
- frame_start  out  1  one-cycle pulse on detected vs rising edge
- overflow  out  1  sticky: a kept pixel was dropped because FIFO full

## Operation
- vs is registered twice (vs_d0, vs_d1); start = vs_d0 && !vs_d1. In the start cycle: frame_start=1, x=1, y=1, x/y phase = 0, sof_pending=1, overflow cleared, FIFO pointers and output register cleared (out_valid=0; previous-frame pixels discarded), config inputs latched into shadow registers. Config changes mid-frame have no effect until the next start.
- After reset the block is disarmed: pixel_de ignored until the first start.
- Counting (1-based): on pixel_de, x increments, wrapping to 1 at x==s_width; y increments when x==s_width, wrapping to 1 at y==s_height.
- Window: in_win = (x > left) && (x <= left+width) && (y > top) && (y <= top+height); sums computed at COORD_BITS+1 bits, no wrap.
- Horizontal phase: reset to 0 at the first in-window pixel of each line, then increments mod h_decim per in-window pixel. Vertical phase: increments mod v_decim at the end of each in-window line (in_win && x==s_width or x==left+width, whichever first).
- keep = pixel_de && armed && in_win && hphase==0 && vphase==0.
- Tags: sof = sof_pending on the kept pixel (sof_pending then clears, even if dropped); eol = keep && (x + h_decim > left+width), computed at COORD_BITS+4 bits.
- Stage 1 registers {keep, sof, eol, pixel_data}; a valid stage-1 entry is written to FIFO memory (width DATA_WIDTH+2) unless full, in which case it is dropped and overflow set.
- Output register loads FIFO head when FIFO non-empty and (!out_valid || out_ready) (first-word fall-through).
- Start coincident with a write: flush wins, write discarded.

## Timing
- Reset values: out_valid=0, out_data=0, out_sof=0, out_eol=0, frame_start=0, overflow=0; armed=0.
- Latency: pixel sampled at edge k with out_ready=1 and empty FIFO appears with out_valid=1 after edge k+3.
- Throughput: one pixel per clock sustained when out_ready=1.
- Capacity before drop: 2^FIFO_ADDR_BITS + 1 pixels.
- out_data/out_sof/out_eol stable while out_valid && !out_ready.
- frame_start asserts the cycle after the vs rising edge is sampled into vs_d0.

## Test plan
- Pass-through: 8x4 frame, data=y*16+x, window 0,0,8,4, decim 1, out_ready=1 -> 32 outputs 0x11..0x48 in order, sof on 0x11, eol on 0x18,0x28,0x38,0x48, first out_valid 3 cycles after first pixel.
- Crop: left=2,width=3,top=1,height=2 -> 0x23,0x24,0x25,0x33,0x34,0x35; eol on 0x25,0x35.
- Decimate: full window, h_decim=2, v_decim=2 -> 0x11,0x13,0x15,0x17,0x31,0x33,0x35,0x37; eol on 0x17,0x37; h_decim=0 behaves as 1.
- Overflow: FIFO_ADDR_BITS=4, out_ready=0, 32 kept pixels -> overflow=1, exactly 17 pixels (0x11..0x31 order) drained afterwards; next vs rise -> overflow=0, out_valid=0.
- Config mid-frame: change clipper_left at y=2 -> current frame uses old window, next frame uses new.
- Reset mid-frame: rst_n low one cycle at y=2 -> all outputs reset values, no output until next vs rising edge, next frame exact.
